// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: retires one Booth digit per clock, WIDTH/2 RUN cycles per product.
// Start/done handshake; start is only honoured in IDLE, product is held between completions.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [2:0]           booth_sel
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   a_sh;   // multiplicand pre-shifted by 2i, so PP needs no variable shifter
  logic [WIDTH:0]  m;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_next;

  always_comb begin
    booth_sel = 3'd3;
    if (state == RUN) begin
      case (m[2:0])
        3'b000:  booth_sel = 3'd3;
        3'b001:  booth_sel = 3'd4;
        3'b010:  booth_sel = 3'd4;
        3'b011:  booth_sel = 3'd5;
        3'b100:  booth_sel = 3'd1;
        3'b101:  booth_sel = 3'd2;
        3'b110:  booth_sel = 3'd2;
        default: booth_sel = 3'd3;
      endcase
    end
  end

  always_comb begin
    pp = '0;
    case (booth_sel)
      3'd1:    pp = -(a_sh << 1);
      3'd2:    pp = -a_sh;
      3'd4:    pp = a_sh;
      3'd5:    pp = a_sh << 1;
      default: pp = '0;
    endcase
    acc_next = acc + pp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_sh    <= '0;
      m       <= '0;
      acc     <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= {{WIDTH{a[WIDTH-1]}}, a};
            m     <= {b, 1'b0};
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          a_sh  <= a_sh << 2;
          m     <= {{2{m[WIDTH]}}, m[WIDTH:2]};
          count <= count + 1'b1;
          if (count == LAST) begin
            product <= acc_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and random checks of booth_seq_mult (WIDTH=8) against an arithmetic reference model.
module tb_booth_seq_mult;

  localparam int WIDTH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic [2*WIDTH-1:0] product;
  logic [2:0]        booth_sel;

  int checks = 0;
  int failures = 0;
  logic [15:0] prev_prod;

  booth_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .booth_sel (booth_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Booth digit i of b is -2*b[2i+1] + b[2i] + b[2i-1] (b[-1]=0); select code = digit + 3.
  function automatic logic [31:0] exp_code(input logic [7:0] bv, input int i);
    int lo;
    int d;
    lo = (i == 0) ? 0 : int'(bv[2*i-1]);
    d  = -2 * int'(bv[2*i+1]) + int'(bv[2*i]) + lo;
    return 32'(d + 3);
  endfunction

  function automatic logic [15:0] exp_prod(input logic [7:0] av, input logic [7:0] bv);
    int pa;
    int pb;
    pa = int'($signed(av));
    pb = int'($signed(bv));
    return 16'(pa * pb);
  endfunction

  // Caller is at a negedge with the DUT in IDLE. Returns at the negedge after the DONE->IDLE edge.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input bit hold, input bit pulse_in_done);
    logic [15:0] expv;
    expv  = exp_prod(av, bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    for (int i = 0; i < WIDTH / 2; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      check($sformatf("busy_run%0d", i), 32'(busy), 32'd1);
      check($sformatf("done_run%0d", i), 32'(done), 32'd0);
      check($sformatf("sel_run%0d b=%0h", i, bv), 32'(booth_sel), exp_code(bv, i));
      check($sformatf("hold_run%0d", i), 32'(product), 32'(prev_prod));
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("sel_done", 32'(booth_sel), 32'd3);
    check($sformatf("product a=%0h b=%0h", av, bv), 32'(product), 32'(expv));
    prev_prod = expv;
    if (pulse_in_done) start = 1'b1;
    @(negedge clk);
    check("done_cleared", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("product_hold", 32'(product), 32'(prev_prod));
    if (pulse_in_done) start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    a     = 8'd5;
    b     = 8'd5;
    prev_prod = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_sel", 32'(booth_sel), 32'd3);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_with_reset_ignored", 32'(busy), 32'd0);

    run_op(8'd7, 8'd3, 1'b0, 1'b0);
    check("a7b3_value", 32'(product), 32'h0015);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h80, 8'h7F, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    run_op(8'h00, 8'h80, 1'b0, 1'b0);
    run_op(8'd5, 8'h55, 1'b0, 1'b0);
    check("a5b55_value", 32'(product), 32'd425);
    run_op(8'd5, 8'hFF, 1'b0, 1'b0);
    check("a5bff_value", 32'(product), 32'hFFFB);

    // start held high: two accepts back to back, each a single operation
    run_op(8'd2, 8'd3, 1'b1, 1'b0);
    a = 8'd2;
    b = 8'd3;
    run_op(8'd2, 8'd3, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check("no_accept_after_hold", 32'(busy), 32'd0);

    // start pulsed while in DONE must not launch an operation
    run_op(8'd9, 8'd11, 1'b0, 1'b1);
    @(negedge clk);
    check("done_start_ignored", 32'(busy), 32'd0);

    // reset during the second RUN cycle aborts without a done pulse
    a = 8'd100;
    b = 8'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check("abort_sel", 32'(booth_sel), 32'd3);
    prev_prod = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_done%0d", k), 32'(done | busy), 32'd0);
    end
    run_op(8'hFD, 8'd9, 1'b0, 1'b0);
    check("am3b9_value", 32'(product), 32'hFFE5);

    // minimum-spacing back-to-back, then a random batch
    for (int k = 0; k < 3; k++) run_op(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
